// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifu_fetch_ctrl_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(fetch_entry_t);

  // Sequential fetch address; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-memory request/response channel between fetch (master) and IMem (slave).
interface ifu_fetch_ctrl_if;
  import ifu_fetch_ctrl_pkg::*;

  logic                  ioIMem_valid;
  logic                  ioIMem_ready;
  logic                  ioIMem_busy;
  logic [ADDR_WIDTH-1:0] ioIMem_pc;
  logic [INST_WIDTH-1:0] ioIMem_inst;

  modport master (
    output ioIMem_valid,
    output ioIMem_pc,
    input  ioIMem_ready,
    input  ioIMem_busy,
    input  ioIMem_inst
  );

  modport slave (
    input  ioIMem_valid,
    input  ioIMem_pc,
    output ioIMem_ready,
    output ioIMem_busy,
    output ioIMem_inst
  );

endinterface

// File: rtl/ifu_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; clear drops all contents.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push != do_pop) count_q <= do_push ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end
  end

  // The fetch credit scheme must never push into a full buffer.
  always @(posedge clk_i) begin
    if (rst_ni && !clear_i) begin
      assert (!(push_i && !do_push)) else $error("fetch_fifo: push into full buffer");
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC, issues IMem reads under a FIFO credit limit,
// buffers returned words and handles redirect flushes.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  ifu_fetch_ctrl_if.master        imem,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0]   out_inst
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_inflight_q, pc_inflight_d;
  logic                  inflight_q, inflight_d;
  logic                  discard_q, discard_d;

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      occupancy;
  logic                  redirect_take;
  logic                  pop;
  logic                  push;
  logic                  req_valid;
  logic                  accept;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  logic                  unused_busy;

  assign unused_busy   = imem.ioIMem_busy;
  assign redirect_take = redirect_valid && (state_q != BOOT);
  assign pop           = out_valid && out_ready && !redirect_take;
  assign push          = inflight_q && !discard_q && !redirect_take;

  // Credit counts the slot freed by this cycle's pop, giving 1 instr/cycle at depth 2.
  assign occupancy = count - CNT_W'(pop) + CNT_W'(inflight_q);
  assign req_valid = (state_q == RUN) && !redirect_valid && (occupancy < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid && imem.ioIMem_ready;

  assign imem.ioIMem_valid = req_valid;
  assign imem.ioIMem_pc    = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    inflight_d    = accept;
    discard_d     = 1'b0;
    case (state_q)
      BOOT:       state_d = RUN;
      RUN, FLUSH: state_d = redirect_take ? FLUSH : RUN;
      default:    state_d = BOOT;
    endcase
    if (redirect_take) begin
      pc_d      = redirect_pc;
      discard_d = inflight_d;
    end else if (accept) begin
      pc_d          = next_pc(pc_q);
      pc_inflight_d = pc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pc_inflight_q <= '0;
      inflight_q    <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
    end
  end

  assign push_entry = '{pc: pc_inflight_q, inst: imem.ioIMem_inst};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fetch_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (redirect_take),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .count_o (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head_entry.pc;
  assign out_inst  = head_entry.inst;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl with a one-cycle-latency IMem model.
module tb_ifu_fetch_ctrl;
  import ifu_fetch_ctrl_pkg::*;

  logic                  clock;
  logic                  reset;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INST_WIDTH-1:0] out_inst;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int base;

  logic                  acc;
  logic [ADDR_WIDTH-1:0] acc_pc;

  ifu_fetch_ctrl_if imem_if ();

  ifu_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .imem           (imem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // IMem model: accepted request returns ~pc during the following cycle.
  always @(negedge clock) begin
    acc    = imem_if.ioIMem_valid && imem_if.ioIMem_ready && reset;
    acc_pc = imem_if.ioIMem_pc;
    if (acc) n_acc++;
  end

  always @(posedge clock) begin
    #1;
    imem_if.ioIMem_inst = acc ? (acc_pc ^ 32'hFFFF_FFFF) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic restart(input logic mem_ready, input logic dec_ready);
    reset                = 1'b0;
    imem_if.ioIMem_ready = mem_ready;
    out_ready            = dec_ready;
    redirect_valid       = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset                = 1'b0;
    redirect_valid       = 1'b0;
    redirect_pc          = '0;
    out_ready            = 1'b1;
    imem_if.ioIMem_ready = 1'b1;
    imem_if.ioIMem_busy  = 1'b0;
    #3;
    check("rst_imem_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    check("rst_out_valid",  32'(out_valid),            32'd0);
    check("rst_out_pc",     out_pc,                    32'd0);
    check("rst_out_inst",   out_inst,                  32'd0);

    // Streaming from reset: first output on the third edge after release.
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    next_cycle(); mid();
    check("t1_c1_out_valid", 32'(out_valid), 32'd0);
    check("t1_c1_req_valid", 32'(imem_if.ioIMem_valid), 32'd1);
    check("t1_c1_req_pc",    imem_if.ioIMem_pc, 32'h8000_0000);
    next_cycle(); mid();
    check("t1_c2_out_valid", 32'(out_valid), 32'd0);
    check("t1_c2_req_pc",    imem_if.ioIMem_pc, 32'h8000_0004);
    next_cycle(); mid();
    check("t1_c3_out_valid", 32'(out_valid), 32'd1);
    check("t1_c3_out_pc",    out_pc,   32'h8000_0000);
    check("t1_c3_out_inst",  out_inst, 32'h7FFF_FFFF);
    next_cycle(); mid();
    check("t1_c4_out_pc",    out_pc,   32'h8000_0004);
    check("t1_c4_out_inst",  out_inst, 32'h7FFF_FFFB);
    next_cycle(); mid();
    check("t1_c5_out_valid", 32'(out_valid), 32'd1);
    check("t1_c5_out_pc",    out_pc,   32'h8000_0008);

    // Decode stalled: only FIFO_DEPTH requests accepted, then in-order drain.
    restart(1'b1, 1'b0);
    base = n_acc;
    for (int i = 1; i <= 6; i++) begin
      next_cycle(); mid();
    end
    check("t2_stall_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    check("t2_stall_out_pc",    out_pc, 32'h8000_0000);
    next_cycle();
    check("t2_accept_count", 32'(n_acc - base), 32'd2);
    out_ready = 1'b1;
    mid();
    check("t2_drain0_out_valid", 32'(out_valid), 32'd1);
    check("t2_drain0_out_pc",    out_pc, 32'h8000_0000);
    check("t2_drain0_req_pc",    imem_if.ioIMem_pc, 32'h8000_0008);
    next_cycle(); mid();
    check("t2_drain1_out_pc",    out_pc, 32'h8000_0004);
    next_cycle(); mid();
    check("t2_drain2_out_pc",    out_pc,   32'h8000_0008);
    check("t2_drain2_out_inst",  out_inst, 32'h7FFF_FFF7);

    // IMem not ready: request held stable, no push.
    restart(1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); mid();
      check($sformatf("t3_hold%0d_req_valid", i), 32'(imem_if.ioIMem_valid), 32'd1);
      check($sformatf("t3_hold%0d_req_pc", i),    imem_if.ioIMem_pc, 32'h8000_0000);
    end
    check("t3_hold_out_valid", 32'(out_valid), 32'd0);
    next_cycle();
    imem_if.ioIMem_ready = 1'b1;
    mid();
    check("t3_accept_req_pc", imem_if.ioIMem_pc, 32'h8000_0000);
    next_cycle(); mid();
    check("t3_next_req_pc",   imem_if.ioIMem_pc, 32'h8000_0004);
    next_cycle(); mid();
    check("t3_out_valid",     32'(out_valid), 32'd1);
    check("t3_out_pc",        out_pc, 32'h8000_0000);

    // Redirect the cycle after an accept: in-flight word is dropped.
    restart(1'b1, 1'b1);
    next_cycle(); mid();
    check("t4_c1_req_pc", imem_if.ioIMem_pc, 32'h8000_0000);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    mid();
    check("t4_redir_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    check("t4_flush_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    check("t4_flush_out_valid", 32'(out_valid), 32'd0);
    next_cycle(); mid();
    check("t4_restart_req_valid", 32'(imem_if.ioIMem_valid), 32'd1);
    check("t4_restart_req_pc",    imem_if.ioIMem_pc, 32'h8000_0100);
    next_cycle(); mid();
    check("t4_c5_out_valid", 32'(out_valid), 32'd0);
    next_cycle(); mid();
    check("t4_c6_out_valid", 32'(out_valid), 32'd1);
    check("t4_c6_out_pc",    out_pc,   32'h8000_0100);
    check("t4_c6_out_inst",  out_inst, 32'h7FFF_FEFF);

    // Redirect coincident with a pop from a full FIFO.
    restart(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); mid();
    end
    check("t5_full_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    next_cycle();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    mid();
    check("t5_redir_out_valid", 32'(out_valid), 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    check("t5_flush_out_valid", 32'(out_valid), 32'd0);
    check("t5_flush_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    next_cycle(); mid();
    check("t5_restart_req_pc", imem_if.ioIMem_pc, 32'h8000_0200);
    next_cycle(); mid();
    check("t5_c8_out_valid", 32'(out_valid), 32'd0);
    next_cycle(); mid();
    check("t5_c9_out_pc",   out_pc,   32'h8000_0200);
    check("t5_c9_out_inst", out_inst, 32'h7FFF_FDFF);

    // Redirect again during FLUSH, to a misaligned address.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    mid();
    next_cycle();
    redirect_pc = 32'h8000_0303;
    mid();
    check("t7_reflush_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    check("t7_flush2_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    next_cycle(); mid();
    check("t7_restart_req_pc", imem_if.ioIMem_pc, 32'h8000_0303);
    next_cycle(); mid();
    check("t7_c14_out_valid", 32'(out_valid), 32'd0);
    next_cycle(); mid();
    check("t7_c15_out_pc",   out_pc,   32'h8000_0303);
    check("t7_c15_out_inst", out_inst, 32'h7FFF_FCFC);
    next_cycle(); mid();
    check("t7_c16_out_pc",    out_pc, 32'h8000_0307);
    check("t6_pre_out_valid", 32'(out_valid), 32'd1);
    check("t6_pre_req_valid", 32'(imem_if.ioIMem_valid), 32'd1);

    // Async reset mid-stream: outputs drop without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_out_valid", 32'(out_valid), 32'd0);
    check("t6_async_req_valid", 32'(imem_if.ioIMem_valid), 32'd0);
    check("t6_async_out_pc",    out_pc, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    next_cycle(); mid();
    check("t6_restart_req_pc", imem_if.ioIMem_pc, 32'h8000_0000);
    next_cycle(); mid();
    next_cycle(); mid();
    check("t6_restart_out_valid", 32'(out_valid), 32'd1);
    check("t6_restart_out_pc",    out_pc, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
